// File: rtl/pipelined_select_addsub.sv
// Pipelined carry-select adder/subtractor.
// WIDTH is cut into BLOCK-bit carry-select blocks; each pipeline stage resolves
// BLKS_PER_STAGE blocks and registers the carry it produces. One beat per cycle,
// LAT = WIDTH/BLOCK/BLKS_PER_STAGE cycles from capture to result.
//
// Handshake: a beat moves on in_valid && in_ready, a result retires on
// out_valid && out_ready. The whole pipe advances together
// (adv = ~out_valid | out_ready) and in_ready equals adv, so a stalled result
// holds every stage, including the one that would take a new input.
module pipelined_select_addsub #(
  parameter int WIDTH          = 16,
  parameter int BLOCK          = 4,
  parameter int BLKS_PER_STAGE = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NBLK = WIDTH / BLOCK;
  localparam int LAT  = NBLK / BLKS_PER_STAGE;
  localparam int SW   = BLKS_PER_STAGE * BLOCK;

  if ((WIDTH % BLOCK) != 0) begin : g_bad_width
    $error("WIDTH must be a multiple of BLOCK");
  end
  if ((NBLK % BLKS_PER_STAGE) != 0) begin : g_bad_stage
    $error("WIDTH/BLOCK must be a multiple of BLKS_PER_STAGE");
  end

  // Plain ripple over one block; returns {carry_out, sum}.
  function automatic logic [BLOCK:0] ripple(input logic [BLOCK-1:0] x,
                                            input logic [BLOCK-1:0] y,
                                            input logic             ci);
    logic [BLOCK-1:0] sm;
    logic             c;
    sm = '0;
    c  = ci;
    for (int i = 0; i < BLOCK; i++) begin
      sm[i] = x[i] ^ y[i] ^ c;
      c     = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    return {c, sm};
  endfunction

  // Stage registers. a/b_eff travel with the beat so later stages can consume
  // their slices; st_sum collects the already-resolved low bits.
  logic [WIDTH-1:0] st_a   [LAT];
  logic [WIDTH-1:0] st_b   [LAT];
  logic [WIDTH-1:0] st_sum [LAT];
  logic [LAT-1:0]   st_c;
  logic [LAT-1:0]   st_v;
  logic             st_ovf;
  logic             st_zero;

  // Per-stage inputs (predecessor register, or the ports for stage 0) and results.
  logic [WIDTH-1:0] src_a   [LAT];
  logic [WIDTH-1:0] src_b   [LAT];
  logic [WIDTH-1:0] src_sum [LAT];
  logic [LAT-1:0]   src_c;
  logic [LAT-1:0]   src_v;
  logic [WIDTH-1:0] nxt_sum [LAT];
  logic [LAT-1:0]   nxt_c;

  logic adv;
  logic fin_ovf;
  logic fin_zero;

  for (genvar k = 0; k < LAT; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign src_a[k]   = a;
      assign src_b[k]   = sub ? ~b : b;
      assign src_sum[k] = '0;
      assign src_c[k]   = cin;
      assign src_v[k]   = in_valid;
    end else begin : g_next
      assign src_a[k]   = st_a[k-1];
      assign src_b[k]   = st_b[k-1];
      assign src_sum[k] = st_sum[k-1];
      assign src_c[k]   = st_c[k-1];
      assign src_v[k]   = st_v[k-1];
    end

    logic [BLKS_PER_STAGE:0] chain;
    logic [SW-1:0]           blk_sum;
    logic [WIDTH-1:0]        stage_sum;

    assign chain[0] = src_c[k];

    for (genvar j = 0; j < BLKS_PER_STAGE; j++) begin : g_blk
      localparam int LO = (k * BLKS_PER_STAGE + j) * BLOCK;
      logic [BLOCK:0] r0;
      logic [BLOCK:0] r1;
      // Both carry-in cases are ready before the incoming carry settles.
      assign r0 = ripple(src_a[k][LO +: BLOCK], src_b[k][LO +: BLOCK], 1'b0);
      assign r1 = ripple(src_a[k][LO +: BLOCK], src_b[k][LO +: BLOCK], 1'b1);
      assign blk_sum[j*BLOCK +: BLOCK] = chain[j] ? r1[BLOCK-1:0] : r0[BLOCK-1:0];
      assign chain[j+1]                = chain[j] ? r1[BLOCK] : r0[BLOCK];
    end

    // Merge this stage's freshly resolved slice into the running sum.
    always_comb begin
      stage_sum                = src_sum[k];
      stage_sum[k*SW +: SW]    = blk_sum;
    end

    assign nxt_sum[k] = stage_sum;
    assign nxt_c[k]   = chain[BLKS_PER_STAGE];
  end

  // Flags are resolved in front of the final register so outputs stay registered.
  assign fin_ovf  = (src_a[LAT-1][WIDTH-1] == src_b[LAT-1][WIDTH-1]) &&
                    (nxt_sum[LAT-1][WIDTH-1] != src_a[LAT-1][WIDTH-1]);
  assign fin_zero = ~|nxt_sum[LAT-1];

  assign adv      = ~st_v[LAT-1] | out_ready;
  assign in_ready = adv;

  // Global-stall pipeline: every stage loads its predecessor when adv, else holds.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < LAT; k++) begin
        st_a[k]   <= '0;
        st_b[k]   <= '0;
        st_sum[k] <= '0;
      end
      st_c    <= '0;
      st_v    <= '0;
      st_ovf  <= 1'b0;
      st_zero <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < LAT; k++) begin
        st_a[k]   <= src_a[k];
        st_b[k]   <= src_b[k];
        st_sum[k] <= nxt_sum[k];
      end
      st_c    <= nxt_c;
      st_v    <= src_v;
      st_ovf  <= fin_ovf;
      st_zero <= fin_zero;
    end
  end

  assign out_valid = st_v[LAT-1];
  assign s         = st_sum[LAT-1];
  assign cout      = st_c[LAT-1];
  assign ovf       = st_ovf;
  assign zero      = st_zero;

endmodule

// File: tb/tb_pipelined_select_addsub.sv
// Testbench for pipelined_select_addsub: a default 16-bit instance (LAT=2)
// and a 32-bit instance (BLOCK=8, BLKS_PER_STAGE=1, LAT=4), each with its own
// expected-result queue filled at acceptance and drained at retirement.
module tb_pipelined_select_addsub;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  // ---------------- 16-bit instance ----------------
  logic        v16, r16, ov16, or16, cin16, sub16, co16, ovf16, z16;
  logic [15:0] a16, b16, s16;

  pipelined_select_addsub dut16 (
    .clk(clk), .reset_n(reset_n), .in_valid(v16), .in_ready(r16),
    .a(a16), .b(b16), .cin(cin16), .sub(sub16),
    .out_valid(ov16), .out_ready(or16),
    .s(s16), .cout(co16), .ovf(ovf16), .zero(z16)
  );

  // ---------------- 32-bit instance ----------------
  logic        v32, r32, ov32, or32, cin32, sub32, co32, ovf32, z32;
  logic [31:0] a32, b32, s32;

  pipelined_select_addsub #(.WIDTH(32), .BLOCK(8), .BLKS_PER_STAGE(1)) dut32 (
    .clk(clk), .reset_n(reset_n), .in_valid(v32), .in_ready(r32),
    .a(a32), .b(b32), .cin(cin32), .sub(sub32),
    .out_valid(ov32), .out_ready(or32),
    .s(s32), .cout(co32), .ovf(ovf32), .zero(z32)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference: plain wide addition, result packed as {cout, ovf, zero, s[31:0]}.
  function automatic logic [34:0] model(input int w, input logic [31:0] x,
                                        input logic [31:0] y, input logic ci,
                                        input logic sb);
    logic [63:0] mask, ye, sum;
    logic [31:0] sm;
    logic        co, ov, z;
    mask = (64'd1 << w) - 64'd1;
    ye   = sb ? (~{32'b0, y}) & mask : {32'b0, y} & mask;
    sum  = {32'b0, x} + ye + {63'b0, ci};
    sm   = sum[31:0] & mask[31:0];
    co   = sum[w];
    ov   = (x[w-1] == ye[w-1]) && (sm[w-1] != x[w-1]);
    z    = (sm == 32'd0);
    return {co, ov, z, sm};
  endfunction

  // ---------------- scoreboard ----------------
  logic [34:0] exp_q16[$];
  logic [34:0] exp_q32[$];
  logic [34:0] e16, e32;
  int rx16 = 0;
  int rx32 = 0;

  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q16.delete();
      exp_q32.delete();
    end else begin
      if (ov16 && or16) begin
        if (exp_q16.size() == 0) check("out16_unexpected", 64'(exp_q16.size()), 64'd1);
        else begin
          e16 = exp_q16.pop_front();
          check("out16", {co16, ovf16, z16, 16'b0, s16}, 64'(e16));
          rx16++;
        end
      end
      if (v16 && r16) exp_q16.push_back(model(16, {16'b0, a16}, {16'b0, b16}, cin16, sub16));
      if (ov32 && or32) begin
        if (exp_q32.size() == 0) check("out32_unexpected", 64'(exp_q32.size()), 64'd1);
        else begin
          e32 = exp_q32.pop_front();
          check("out32", {co32, ovf32, z32, s32}, 64'(e32));
          rx32++;
        end
      end
      if (v32 && r32) exp_q32.push_back(model(32, a32, b32, cin32, sub32));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat on the 16-bit instance and hold it until accepted.
  task automatic send16(input logic [15:0] x, input logic [15:0] y,
                        input logic ci, input logic sb);
    int guard;
    v16 = 1'b1; a16 = x; b16 = y; cin16 = ci; sub16 = sb;
    guard = 0;
    while (!r16 && guard < 50) begin
      tick();
      guard++;
    end
    if (!r16) check("send16_timeout", 64'(r16), 64'd1);
    tick();
    v16 = 1'b0;
  endtask

  // Single beat with known answer; also measures capture-to-output latency.
  task automatic directed16(input string tag, input logic [15:0] x, input logic [15:0] y,
                            input logic ci, input logic sb, input logic [15:0] es,
                            input logic eco, input logic eov, input logic ez);
    int edges;
    send16(x, y, ci, sb);
    edges = 1;
    while (!ov16 && edges < 10) begin
      tick();
      edges++;
    end
    check({tag, "_lat"}, 64'(edges), 64'd2);
    check({tag, "_s"}, 64'(s16), 64'(es));
    check({tag, "_cout"}, 64'(co16), 64'(eco));
    check({tag, "_ovf"}, 64'(ovf16), 64'(eov));
    check({tag, "_zero"}, 64'(z16), 64'(ez));
    tick();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int   i, cyc, rx0, edges, accepted;
    logic acc, stalled_prev, pending;
    logic [15:0] held;

    reset_n = 1'b0;
    v16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0; or16 = 1'b1;
    v32 = 1'b0; a32 = '0; b32 = '0; cin32 = 1'b0; sub32 = 1'b0; or32 = 1'b1;
    repeat (3) tick();

    // Reset state
    check("rst_out_valid", 64'(ov16), 64'd0);
    check("rst_s", 64'(s16), 64'd0);
    check("rst_cout", 64'(co16), 64'd0);
    check("rst_ovf", 64'(ovf16), 64'd0);
    check("rst_zero", 64'(z16), 64'd0);
    check("rst_out_valid32", 64'(ov32), 64'd0);
    reset_n = 1'b1;
    check("rst_in_ready", 64'(r16), 64'd1);

    // Add / subtract with known answers
    directed16("add_basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
    directed16("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    directed16("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    directed16("sub_neg",   16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    directed16("sub_ovf",   16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);

    // Backpressure: 6 beats, out_ready low for cycles 3..5
    i = 1; cyc = 0; rx0 = rx16; stalled_prev = 1'b0; held = '0;
    while ((i <= 6 || ov16 || exp_q16.size() != 0) && cyc < 40) begin
      or16 = !(cyc >= 3 && cyc <= 5);
      v16 = (i <= 6); a16 = 16'(i); b16 = 16'h0100; cin16 = 1'b0; sub16 = 1'b0;
      #1;
      check("bp_in_ready", 64'(r16), 64'(!(ov16 && !or16)));
      if (stalled_prev) check("bp_hold", 64'(s16), 64'(held));
      stalled_prev = ov16 && !or16;
      held = s16;
      acc = v16 && r16;
      tick();
      if (acc) i++;
      cyc++;
    end
    v16 = 1'b0; or16 = 1'b1;
    check("bp_count", 64'(rx16 - rx0), 64'd6);

    // Reset while two beats are in flight (output stalled so neither retires)
    or16 = 1'b0;
    v16 = 1'b1; a16 = 16'h1111; b16 = 16'h0001; cin16 = 1'b0; sub16 = 1'b0;
    tick();
    a16 = 16'h2222;
    tick();
    v16 = 1'b0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("mid_rst_out_valid", 64'(ov16), 64'd0);
    check("mid_rst_s", 64'(s16), 64'd0);
    check("mid_rst_in_ready", 64'(r16), 64'd1);
    or16 = 1'b1;
    rx0 = rx16;
    directed16("after_rst", 16'h0002, 16'h0003, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0, 1'b0);
    repeat (4) tick();
    check("after_rst_count", 64'(rx16 - rx0), 64'd1);

    // Random 16-bit traffic with random backpressure
    accepted = 0; cyc = 0; pending = 1'b0; rx0 = rx16;
    while (accepted < 300 && cyc < 3000) begin
      if (!pending) begin
        v16 = ($urandom_range(0, 3) != 0);
        a16 = 16'($urandom); b16 = 16'($urandom);
        cin16 = 1'($urandom_range(0, 1)); sub16 = 1'($urandom_range(0, 1));
      end
      or16 = ($urandom_range(0, 3) != 0);
      #1;
      acc = v16 && r16;
      tick();
      if (acc) accepted++;
      pending = v16 && !acc;
      cyc++;
    end
    v16 = 1'b0; or16 = 1'b1;
    cyc = 0;
    while (exp_q16.size() != 0 && cyc < 20) begin
      tick();
      cyc++;
    end
    check("rand16_drain", 64'(exp_q16.size()), 64'd0);
    check("rand16_count", 64'(rx16 - rx0), 64'(accepted));

    // 32-bit instance: wrap-around and latency of 4
    v32 = 1'b1; a32 = 32'hFFFF_FFFF; b32 = 32'h0000_0001; cin32 = 1'b0; sub32 = 1'b0;
    tick();
    v32 = 1'b0;
    edges = 1;
    while (!ov32 && edges < 10) begin
      tick();
      edges++;
    end
    check("w32_lat", 64'(edges), 64'd4);
    check("w32_s", 64'(s32), 64'd0);
    check("w32_cout", 64'(co32), 64'd1);
    check("w32_zero", 64'(z32), 64'd1);
    tick();

    // 32-bit random stream, 10k beats, random out_ready
    accepted = 0; cyc = 0; pending = 1'b0; rx0 = rx32;
    while (accepted < 10000 && cyc < 60000) begin
      if (!pending) begin
        v32 = ($urandom_range(0, 3) != 0);
        a32 = $urandom; b32 = $urandom;
        cin32 = 1'($urandom_range(0, 1)); sub32 = 1'($urandom_range(0, 1));
      end
      or32 = ($urandom_range(0, 3) != 0);
      #1;
      acc = v32 && r32;
      tick();
      if (acc) accepted++;
      pending = v32 && !acc;
      cyc++;
    end
    check("rand32_accepted", 64'(accepted), 64'd10000);
    v32 = 1'b0; or32 = 1'b1;
    cyc = 0;
    while (exp_q32.size() != 0 && cyc < 20) begin
      tick();
      cyc++;
    end
    check("rand32_drain", 64'(exp_q32.size()), 64'd0);
    check("rand32_count", 64'(rx32 - rx0), 64'(accepted));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
